// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60Hz raster timing and window decode helper
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    // Half-open window test on 11-bit values so a 10-bit count never overflows the compare.
    function automatic logic in_window(input logic [10:0] x, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_timing_controller_pixel_tick_gen.sv
// rtl/vga_timing_controller_pixel_tick_gen.sv - system clock divider producing the registered pixel_tick strobe
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;

    always_comb begin
        div_next = (div >= LAST) ? '0 : div + DW'(1);
    end

    // Strobe is decoded from the next divider value so it lines up with div==CLK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            pixel_tick <= 1'b0;
        end else begin
            div        <= div_next;
            pixel_tick <= (div_next == LAST);
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - VGA raster counters with registered sync, display and frame_start outputs
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       display_pixel,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam logic [10:0] H_TOTAL     = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [10:0] V_TOTAL     = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [10:0] H_VIS_START = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VIS_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_VIS_START = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_VIS_END   = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_last;
    logic       v_last;
    logic       wrap;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_pixel_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_tick (pixel_tick)
    );

    // ">=" rather than "==" folds any unreachable out-of-range count back to 0.
    always_comb begin
        h_last = ({1'b0, hcount} >= H_TOTAL - 11'd1);
        v_last = ({1'b0, vcount} >= V_TOTAL - 11'd1);
        h_next = hcount;
        v_next = vcount;
        wrap   = 1'b0;
        if (pixel_tick) begin
            h_next = h_last ? 10'd0 : hcount + 10'd1;
            if ({1'b0, vcount} > V_TOTAL - 11'd1) begin
                v_next = 10'd0;
            end else if (h_last) begin
                v_next = v_last ? 10'd0 : vcount + 10'd1;
                wrap   = v_last;
            end
        end
    end

    // Outputs decode the next counts so they stay cycle-aligned with hcount/vcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount        <= 10'd0;
            vcount        <= 10'd0;
            hsync         <= 1'b0;
            vsync         <= 1'b0;
            display_pixel <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            hcount        <= h_next;
            vcount        <= v_next;
            hsync         <= ({1'b0, h_next} >= H_SYNC_END);
            vsync         <= ({1'b0, v_next} >= V_SYNC_END);
            display_pixel <= in_window({1'b0, h_next}, H_VIS_START, H_VIS_END) &&
                             in_window({1'b0, v_next}, V_VIS_START, V_VIS_END);
            frame_start   <= wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - randomized self-checking bench against a pixel-index raster model
module tb_vga_timing_controller;

    typedef struct {
        int d, hs, hbp, hact, hfp, vs, vbp, vact, vfp;
    } timing_t;

    typedef struct {
        int h, v;
        bit hsync, vsync, disp, tick, fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hc[3];
    logic [9:0] vc[3];
    logic       hs_o[3];
    logic       vs_o[3];
    logic       dp_o[3];
    logic       tk_o[3];
    logic       fs_o[3];

    int n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Clock edges seen since reset release; the whole expected raster derives from this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    vga_timing_controller #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .hcount(hc[0]), .vcount(vc[0]), .hsync(hs_o[0]),
        .vsync(vs_o[0]), .display_pixel(dp_o[0]), .pixel_tick(tk_o[0]), .frame_start(fs_o[0])
    );

    vga_timing_controller #(
        .CLK_DIV(1), .H_SYNC(5), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(3)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hcount(hc[1]), .vcount(vc[1]), .hsync(hs_o[1]),
        .vsync(vs_o[1]), .display_pixel(dp_o[1]), .pixel_tick(tk_o[1]), .frame_start(fs_o[1])
    );

    vga_timing_controller #(
        .CLK_DIV(3), .H_SYNC(5), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(3)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .hcount(hc[2]), .vcount(vc[2]), .hsync(hs_o[2]),
        .vsync(vs_o[2]), .display_pixel(dp_o[2]), .pixel_tick(tk_o[2]), .frame_start(fs_o[2])
    );

    function automatic timing_t tm(int i);
        timing_t t;
        if (i == 0) t = '{2, 96, 48, 640, 16, 2, 33, 480, 10};
        else        t = '{(i == 1) ? 1 : 3, 5, 3, 8, 2, 2, 2, 5, 3};
        return t;
    endfunction

    // Pixels elapsed after nn edges: the first strobe appears one edge after release,
    // and each strobe advances the raster on the following edge.
    function automatic int pix(int d, int nn);
        if (nn <= 0) return 0;
        if (d == 1)  return nn - 1;
        return nn / d;
    endfunction

    function automatic exp_t model(int i, int nn);
        timing_t t;
        exp_t    e;
        int      p, pp, ht, vt;
        t  = tm(i);
        ht = t.hs + t.hbp + t.hact + t.hfp;
        vt = t.vs + t.vbp + t.vact + t.vfp;
        p  = pix(t.d, nn);
        pp = pix(t.d, nn - 1);
        e.h     = p % ht;
        e.v     = (p / ht) % vt;
        e.hsync = (e.h >= t.hs);
        e.vsync = (e.v >= t.vs);
        e.disp  = (e.h >= t.hs + t.hbp) && (e.h < t.hs + t.hbp + t.hact) &&
                  (e.v >= t.vs + t.vbp) && (e.v < t.vs + t.vbp + t.vact);
        e.tick  = (nn >= 1) && ((nn % t.d) == t.d - 1);
        e.fs    = (p != pp) && ((p % (ht * vt)) == 0);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hc[i] !== 10'd0 || vc[i] !== 10'd0 || hs_o[i] !== 1'b0 || vs_o[i] !== 1'b0 ||
                dp_o[i] !== 1'b0 || tk_o[i] !== 1'b0 || fs_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d got h=%0d v=%0d hs=%b vs=%b dp=%b tk=%b fs=%b required all 0",
                         i, hc[i], vc[i], hs_o[i], vs_o[i], dp_o[i], tk_o[i], fs_o[i]);
            end
        end
    endtask

    task automatic test_divider();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = model(0, n);
            checks++;
            if (tk_o[0] !== e.tick || hc[0] !== e.h[9:0]) begin
                errors++;
                $display("FAIL divider cycle %0d got tick=%b h=%0d required tick=%b h=%0d",
                         k, tk_o[0], hc[0], e.tick, e.h);
            end
        end
        for (int k = 0; k < 400 && model(0, n).h != 95; k++) @(negedge clk);
        checks++;
        if (hc[0] !== 10'd95 || hs_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL hsync_low_end got h=%0d hs=%b required h=95 hs=0", hc[0], hs_o[0]);
        end
        for (int k = 0; k < 4 && model(0, n).h != 96; k++) @(negedge clk);
        checks++;
        if (hc[0] !== 10'd96 || hs_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL hsync_rise got h=%0d hs=%b required h=96 hs=1", hc[0], hs_o[0]);
        end
    endtask

    task automatic test_line_wrap();
        for (int k = 0; k < 20000 && !(model(0, n).h == 799 && model(0, n).v == 10); k++)
            @(negedge clk);
        checks++;
        if (hc[0] !== 10'd799 || vc[0] !== 10'd10) begin
            errors++;
            $display("FAIL line_end got (%0d,%0d) required (799,10)", hc[0], vc[0]);
        end
        for (int k = 0; k < 4 && model(0, n).h != 0; k++) @(negedge clk);
        checks++;
        if (hc[0] !== 10'd0 || vc[0] !== 10'd11) begin
            errors++;
            $display("FAIL line_wrap got (%0d,%0d) required (0,11)", hc[0], vc[0]);
        end
    endtask

    task automatic test_frame_wrap();
        int lows, pulses, vlows, gap;
        logic prev_hs;
        for (int k = 0; k < 400 && !(model(1, n).h == 17 && model(1, n).v == 11); k++)
            @(negedge clk);
        checks++;
        if (hc[1] !== 10'd17 || vc[1] !== 10'd11 || fs_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL frame_end got (%0d,%0d) fs=%b required (17,11) fs=0", hc[1], vc[1], fs_o[1]);
        end
        @(negedge clk);
        checks++;
        if (hc[1] !== 10'd0 || vc[1] !== 10'd0 || fs_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap got (%0d,%0d) fs=%b required (0,0) fs=1", hc[1], vc[1], fs_o[1]);
        end
        lows = 0; pulses = 0; vlows = 0; gap = 0; prev_hs = 1'b1;
        do begin
            if (!hs_o[1]) lows++;
            if (!hs_o[1] && prev_hs) pulses++;
            if (!vs_o[1]) vlows++;
            prev_hs = hs_o[1];
            @(negedge clk);
            gap++;
        end while (fs_o[1] !== 1'b1 && gap < 1000);
        checks++;
        if (gap != 216) begin
            errors++;
            $display("FAIL frame_period got %0d clk required 216", gap);
        end
        checks++;
        if (pulses != 12 || lows != 60 || vlows != 36) begin
            errors++;
            $display("FAIL sync_counts got pulses=%0d hlow=%0d vlow=%0d required 12 60 36",
                     pulses, lows, vlows);
        end
        @(negedge clk);
        checks++;
        if (fs_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_width got fs=%b required 0", fs_o[1]);
        end
    endtask

    task automatic test_window();
        int th[5] = '{7, 8, 15, 16, 8};
        int tv[5] = '{4, 4, 8, 8, 9};
        bit td[5] = '{0, 1, 1, 0, 0};
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 300 && !(model(1, n).h == th[j] && model(1, n).v == tv[j]); k++)
                @(negedge clk);
            checks++;
            if (hc[1] !== th[j][9:0] || vc[1] !== tv[j][9:0] || dp_o[1] !== td[j]) begin
                errors++;
                $display("FAIL window%0d got (%0d,%0d) dp=%b required (%0d,%0d) dp=%b",
                         j, hc[1], vc[1], dp_o[1], th[j], tv[j], td[j]);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        repeat ($urandom_range(50, 200)) @(negedge clk);
        @(posedge clk);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hc[i] !== 10'd0 || vc[i] !== 10'd0 || hs_o[i] !== 1'b0 || vs_o[i] !== 1'b0 ||
                dp_o[i] !== 1'b0 || tk_o[i] !== 1'b0 || fs_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d got h=%0d v=%0d hs=%b vs=%b dp=%b tk=%b fs=%b required all 0",
                         i, hc[i], vc[i], hs_o[i], vs_o[i], dp_o[i], tk_o[i], fs_o[i]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = model(i, n);
            checks++;
            if (hc[i] !== e.h[9:0] || vc[i] !== e.v[9:0]) begin
                errors++;
                $display("FAIL restart dut%0d got (%0d,%0d) required (%0d,%0d)",
                         i, hc[i], vc[i], e.h, e.v);
            end
        end
    endtask

    task automatic test_random_run();
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(20, 400)) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    e = model(i, n);
                    checks++;
                    if (hc[i] !== e.h[9:0] || vc[i] !== e.v[9:0] || hs_o[i] !== e.hsync ||
                        vs_o[i] !== e.vsync || dp_o[i] !== e.disp || tk_o[i] !== e.tick ||
                        fs_o[i] !== e.fs) begin
                        errors++;
                        $display("FAIL random dut%0d n=%0d got h=%0d v=%0d hs=%b vs=%b dp=%b tk=%b fs=%b required h=%0d v=%0d hs=%b vs=%b dp=%b tk=%b fs=%b",
                                 i, n, hc[i], vc[i], hs_o[i], vs_o[i], dp_o[i], tk_o[i], fs_o[i],
                                 e.h, e.v, e.hsync, e.vsync, e.disp, e.tick, e.fs);
                    end
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                #($urandom_range(1, 4));
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_line_wrap();
        test_frame_wrap();
        test_window();
        test_async_reset();
        test_random_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
